// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register plus IF/ID pipeline register with redirect/stall priority.
// Optional redirect counter enabled by defining FETCH_REDIRECT_CNT_EN.
module fetch_stage #(
  parameter int unsigned PW  = 9,
  parameter logic [31:0] NOP = 32'h0000_0013
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          stall,
  input  logic          pc_sel,
  input  logic [31:0]   pc_branch,
  output logic [PW-1:0] imem_addr,
  input  logic [31:0]   imem_rdata,
  output logic [PW-1:0] if_id_pc,
  output logic [31:0]   if_id_instr,
  output logic          if_id_valid,
  output logic          misalign,
  output logic [15:0]   redirect_cnt
);

  logic [PW-1:0] pc_q, pc_d;
  logic [PW-1:0] id_pc_q, id_pc_d;
  logic [31:0]   id_instr_q, id_instr_d;
  logic          id_valid_q, id_valid_d;
  logic          misalign_q, misalign_d;

  // Target bits above the PC width are dropped by design.
  logic unused_branch_hi;
  assign unused_branch_hi = ^pc_branch[31:PW];

  always_comb begin
    pc_d       = pc_q;
    id_pc_d    = id_pc_q;
    id_instr_d = id_instr_q;
    id_valid_d = id_valid_q;
    misalign_d = 1'b0;
    if (pc_sel) begin
      pc_d       = {pc_branch[PW-1:2], 2'b00};
      id_pc_d    = pc_q;
      id_instr_d = NOP;
      id_valid_d = 1'b0;
      misalign_d = |pc_branch[1:0];
    end else if (!stall) begin
      pc_d       = pc_q + PW'(4);
      id_pc_d    = pc_q;
      id_instr_d = imem_rdata;
      id_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q       <= '0;
      id_pc_q    <= '0;
      id_instr_q <= NOP;
      id_valid_q <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      id_pc_q    <= id_pc_d;
      id_instr_q <= id_instr_d;
      id_valid_q <= id_valid_d;
      misalign_q <= misalign_d;
    end
  end

`ifdef FETCH_REDIRECT_CNT_EN
  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (pc_sel && (cnt_q != 16'hFFFF)) cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign redirect_cnt = cnt_q;
`else
  assign redirect_cnt = '0;
`endif

  assign imem_addr   = pc_q;
  assign if_id_pc    = id_pc_q;
  assign if_id_instr = id_instr_q;
  assign if_id_valid = id_valid_q;
  assign misalign    = misalign_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: stimulus pushes expected post-edge state, a monitor
// pops and compares one entry at every falling clock edge.
module tb_fetch_stage;

  localparam int unsigned PW = 9;
  localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef FETCH_REDIRECT_CNT_EN
  localparam bit CntEn = 1'b1;
`else
  localparam bit CntEn = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset_n;
  logic          stall, pc_sel;
  logic [31:0]   pc_branch;
  logic [PW-1:0] imem_addr;
  logic [31:0]   imem_rdata;
  logic [PW-1:0] if_id_pc;
  logic [31:0]   if_id_instr;
  logic          if_id_valid, misalign;
  logic [15:0]   redirect_cnt;

  fetch_stage #(.PW(PW), .NOP(NOP)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .stall        (stall),
    .pc_sel       (pc_sel),
    .pc_branch    (pc_branch),
    .imem_addr    (imem_addr),
    .imem_rdata   (imem_rdata),
    .if_id_pc     (if_id_pc),
    .if_id_instr  (if_id_instr),
    .if_id_valid  (if_id_valid),
    .misalign     (misalign),
    .redirect_cnt (redirect_cnt)
  );

  always #5 clk = ~clk;

  // Instruction memory model: word = 0x1000_0000 + address.
  assign imem_rdata = 32'h1000_0000 + 32'(imem_addr);

  typedef struct {
    int          id;
    logic [31:0] pc;
    logic [31:0] ifpc;
    logic [31:0] instr;
    logic [31:0] valid;
    logic [31:0] mis;
    logic [31:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_pass = 0;
  int   n_total = 0;
  int   step_id = 0;

  function automatic void chk(input int id, input string name,
                              input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act !== req)
      $display("FAIL step%0d %s: got %h expected %h", id, name, act, req);
    else
      n_pass++;
  endfunction

  function automatic logic [31:0] ecnt(input int n);
    return CntEn ? 32'(n) : 32'd0;
  endfunction

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk(e.id, "imem_addr",    32'(imem_addr),    e.pc);
        chk(e.id, "if_id_pc",     32'(if_id_pc),     e.ifpc);
        chk(e.id, "if_id_instr",  if_id_instr,       e.instr);
        chk(e.id, "if_id_valid",  32'(if_id_valid),  e.valid);
        chk(e.id, "misalign",     32'(misalign),     e.mis);
        chk(e.id, "redirect_cnt", 32'(redirect_cnt), e.cnt);
      end
    end
  end

  task automatic expect_state(input logic [31:0] pc, input logic [31:0] ifpc,
                              input logic [31:0] instr, input logic valid,
                              input logic mis, input logic [31:0] cnt);
    exp_t e;
    step_id++;
    e.id = step_id; e.pc = pc; e.ifpc = ifpc; e.instr = instr;
    e.valid = 32'(valid); e.mis = 32'(mis); e.cnt = cnt;
    exp_q.push_back(e);
  endtask

  // Drive inputs, record the state expected after the next rising edge, wait for the check.
  task automatic step(input logic st, input logic sel, input logic [31:0] br,
                      input logic [31:0] pc, input logic [31:0] ifpc,
                      input logic [31:0] instr, input logic valid,
                      input logic mis, input logic [31:0] cnt);
    stall = st; pc_sel = sel; pc_branch = br;
    expect_state(pc, ifpc, instr, valid, mis, cnt);
    @(negedge clk); #1;
  endtask

  task automatic step_nochk(input logic st, input logic sel, input logic [31:0] br);
    stall = st; pc_sel = sel; pc_branch = br;
    @(negedge clk); #1;
  endtask

  initial begin : stim
    int guard;
    reset_n = 1'b0; stall = 1'b0; pc_sel = 1'b0; pc_branch = '0;
    expect_state(0, 0, NOP, 0, 0, 0);
    @(negedge clk); #1;
    reset_n = 1'b1;

    // Advance, then 3-cycle stall at pc=8
    step(0, 0, 0,     4,     0, 32'h1000_0000, 1, 0, ecnt(0));
    step(0, 0, 0,     8,     4, 32'h1000_0004, 1, 0, ecnt(0));
    step(1, 0, 0,     8,     4, 32'h1000_0004, 1, 0, ecnt(0));
    step(1, 0, 0,     8,     4, 32'h1000_0004, 1, 0, ecnt(0));
    step(1, 0, 0,     8,     4, 32'h1000_0004, 1, 0, ecnt(0));
    step(0, 0, 0,    12,     8, 32'h1000_0008, 1, 0, ecnt(0));
    step(0, 0, 0,    16,    12, 32'h1000_000C, 1, 0, ecnt(0));
    // Redirect wins over a simultaneous stall
    step(1, 1, 32'h0000_0040, 32'h40, 16, NOP, 0, 0, ecnt(1));
    step(0, 0, 0,  32'h44, 32'h40, 32'h1000_0040, 1, 0, ecnt(1));
    // Truncated, misaligned target then wrap-around
    step(0, 1, 32'hFFFF_F1FE, 32'h1FC, 32'h44, NOP, 0, 1, ecnt(2));
    step(0, 0, 0,      0, 32'h1FC, 32'h1000_01FC, 1, 0, ecnt(2));
    // Back-to-back redirects
    step(0, 1, 32'h0000_0008, 8,      0,      NOP, 0, 0, ecnt(3));
    step(0, 1, 32'h0000_0011, 32'h10, 8,      NOP, 0, 1, ecnt(4));
    step(1, 1, 32'h0000_0103, 32'h100, 32'h10, NOP, 0, 1, ecnt(5));
    step(1, 0, 0,    32'h100, 32'h10, NOP, 0, 0, ecnt(5));
    step(0, 0, 0,    32'h104, 32'h100, 32'h1000_0100, 1, 0, ecnt(5));
    step(1, 0, 0,    32'h104, 32'h100, 32'h1000_0100, 1, 0, ecnt(5));

    // Asynchronous reset between edges while stalled; checked before the next rising edge
    @(posedge clk); #1;
    reset_n = 1'b0;
    expect_state(0, 0, NOP, 0, 0, 0);
    @(negedge clk); #1;
    // Reset overrides a pending redirect
    stall = 1'b1; pc_sel = 1'b1; pc_branch = 32'h0000_0080;
    expect_state(0, 0, NOP, 0, 0, 0);
    @(negedge clk); #1;
    reset_n = 1'b1;
    step(1, 0, 0, 0, 0, NOP, 0, 0, ecnt(0));
    step(0, 0, 0, 4, 0, 32'h1000_0000, 1, 0, ecnt(0));

    // Counter saturation: 65537 redirects in total
    for (int i = 0; i < 65536; i++) step_nochk(0, 1, 32'h0000_0020);
    step(0, 1, 32'h0000_0020, 32'h20, 32'h20, NOP, 0, 0, CntEn ? 32'hFFFF : 32'd0);
    step(0, 0, 0, 32'h24, 32'h20, 32'h1000_0020, 1, 0, CntEn ? 32'hFFFF : 32'd0);

    guard = 0;
    while (exp_q.size() > 0 && guard < 10) begin
      @(negedge clk); #1;
      guard++;
    end
    if (exp_q.size() > 0) begin
      n_total++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
